pc_sequencer: RTL and testbench

Fetch-side program-counter controller for the single-cycle CPU core. Owns the 32-bit PC register, sequences one instruction fetch at a time over a request/acknowledge interface to instruction memory, and presents the fetched word to decode. On each accepted instruction it selects the next PC from trap, jump, branch or sequential sources. It replaces the bare PC flop with a stall-aware, redirect-aware sequencer.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/pc_sequencer_pc_reg.sv | 31 +++
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg: fetch-side shared types and constants for the CPU core.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [31:0] WORD_BYTES   = 32'd4;
  localparam logic [31:0] c_ALIGN_MASK = WORD_BYTES - 32'd1;
  localparam logic [31:0] c_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] c_TRAP_VEC   = 32'h0000_0080;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr & c_ALIGN_MASK) != 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_pc_reg.sv
// +----------------------------------------------------------------------+
// | pc_reg: 32-bit load-enabled register, sync reset to RESET_VALUE.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_reg #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +----------------------------------------------------------------------+
// | pc_sequencer: stall/redirect-aware PC and single-fetch sequencer.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_RESET_PC,
  parameter logic [31:0] TRAP_VEC = c_TRAP_VEC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        trap,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        misalign
);

  state_t      r_state;
  logic        r_imem_req;
  logic        r_inst_valid;
  logic        r_misalign;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic [31:0] w_pc;
  logic [31:0] w_next_pc;
  logic        w_bad_target;
  logic        w_accept;

  assign w_accept = (r_state == ISSUE) && !stall;

  // Redirect priority: trap, jump, branch, sequential; bad targets trap.
  always_comb begin
    w_next_pc    = w_pc + WORD_BYTES;
    w_bad_target = 1'b0;
    if (trap) begin
      w_next_pc = TRAP_VEC;
    end else if (jmp) begin
      if (is_misaligned(jmp_target)) begin
        w_next_pc    = TRAP_VEC;
        w_bad_target = 1'b1;
      end else begin
        w_next_pc = jmp_target;
      end
    end else if (br_taken) begin
      if (is_misaligned(br_target)) begin
        w_next_pc    = TRAP_VEC;
        w_bad_target = 1'b1;
      end else begin
        w_next_pc = br_target;
      end
    end
  end

  pc_reg #(
    .RESET_VALUE (RESET_PC)
  ) u_pc_reg (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_accept),
    .i_d    (w_next_pc),
    .o_q    (w_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= BOOT;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            r_inst       <= imem_rdata;
            r_inst_pc    <= w_pc;
            r_inst_valid <= 1'b1;
            r_imem_req   <= 1'b0;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            r_inst_valid <= 1'b0;
            r_misalign   <= w_bad_target;
            if (halt) begin
              r_state <= HALTED;
            end else begin
              r_state    <= FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end
        HALTED: begin
        end
        default: begin
          r_state <= BOOT;
        end
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = w_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;
  assign pc         = w_pc;
  assign misalign   = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_pc_sequencer: directed bench with a cycle-level reference model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAPV  = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_target = 32'd0;
  logic        trap = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory responder: ack after ack_delay waiting cycles, or manual drive.
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        r_ack = 1'b0;
  logic [31:0] r_rdata = 32'd0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'd0;

  assign imem_ack   = ack_en ? r_ack : man_ack;
  assign imem_rdata = ack_en ? r_rdata : man_rdata;

  pc_sequencer #(.RESET_PC(RST_PC), .TRAP_VEC(TRAPV)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .trap(trap), .halt(halt), .pc(pc),
    .misalign(misalign)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (imem_req) begin
      if (wait_cnt == ack_delay) begin
        r_ack = 1'b1; r_rdata = mem_word(imem_addr); wait_cnt = 0;
      end else begin
        r_ack = 1'b0; wait_cnt++;
      end
    end else begin
      r_ack = 1'b0; wait_cnt = 0;
    end
  end

  // Reference model: expectations for the next cycle from this cycle's inputs.
  logic        live = 1'b0, booting = 1'b0;
  logic        exp_req, exp_valid, exp_mis, bad;
  logic [31:0] exp_pc, exp_inst, exp_ipc, tgt;

  always @(negedge clock) begin
    if (live) begin
      check("m_req", 32'(imem_req), 32'(exp_req));
      check("m_valid", 32'(inst_valid), 32'(exp_valid));
      check("m_misalign", 32'(misalign), 32'(exp_mis));
      check("m_pc", pc, exp_pc);
      check("m_inst", inst, exp_inst);
      check("m_inst_pc", inst_pc, exp_ipc);
      if (exp_req) check("m_addr", imem_addr, exp_pc);
    end
    if (reset) begin
      live = 1'b1; booting = 1'b1;
      exp_req = 1'b0; exp_valid = 1'b0; exp_mis = 1'b0;
      exp_pc = RST_PC; exp_inst = 32'd0; exp_ipc = 32'd0;
    end else if (live) begin
      exp_mis = 1'b0;
      if (booting) begin
        booting = 1'b0; exp_req = 1'b1;
      end else if (exp_req) begin
        if (imem_ack) begin
          exp_req = 1'b0; exp_valid = 1'b1; exp_inst = imem_rdata; exp_ipc = exp_pc;
        end
      end else if (exp_valid && !stall) begin
        if (trap) tgt = TRAPV;
        else if (jmp) tgt = jmp_target;
        else if (br_taken) tgt = br_target;
        else tgt = exp_pc + 32'd4;
        bad = !trap && (jmp || br_taken) && (tgt % 4 != 0);
        exp_pc = bad ? TRAPV : tgt;
        exp_mis = bad;
        exp_valid = 1'b0;
        exp_req = !halt;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid && n < 50) begin tick(); n++; end
    if (!inst_valid) check("timeout_valid", 32'd0, 32'd1);
  endtask

  task automatic wait_req(output logic [31:0] a);
    int n = 0;
    while (!imem_req && n < 50) begin tick(); n++; end
    if (!imem_req) check("timeout_req", 32'd0, 32'd1);
    a = imem_addr;
  endtask

  task automatic accept_with(input logic t, input logic j, input logic [31:0] jt,
                             input logic b, input logic [31:0] bt, input logic h);
    wait_valid();
    trap = t; jmp = j; jmp_target = jt; br_taken = b; br_target = bt; halt = h; stall = 1'b0;
    tick();
    trap = 1'b0; jmp = 1'b0; br_taken = 1'b0; halt = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] addrs[$];
    int          starts[$];
    logic        prev;
    logic        held;
    int          n;

    tick(); tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    reset = 1'b0;

    // Zero-wait fetch stream: one request every two cycles starting next cycle.
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (imem_req && !prev) begin addrs.push_back(imem_addr); starts.push_back(i); end
      prev = imem_req;
    end
    check("seq_count", addrs.size(), 32'd3);
    if (addrs.size() == 3) begin
      check("first_req_cycle", starts[0], 32'd0);
      check("seq_a0", addrs[0], 32'h0);
      check("seq_a1", addrs[1], 32'h4);
      check("seq_a2", addrs[2], 32'h8);
      check("seq_gap", starts[2] - starts[1], 32'd2);
    end
    check("seq_inst_pc", inst_pc, 32'h8);
    check("seq_inst", inst, mem_word(32'h8));

    // Three-cycle ack latency on the fetch at 0x10.
    n = 0;
    while (!(inst_valid && inst_pc == 32'hC) && n < 20) begin tick(); n++; end
    ack_delay = 3;
    tick();
    n = 0; held = 1'b1;
    while (imem_req && n < 20) begin
      if (imem_addr !== 32'h10) held = 1'b0;
      n++; tick();
    end
    ack_delay = 0;
    check("lat_req_cycles", n, 32'd4);
    check("lat_addr_held", 32'(held), 32'd1);
    check("lat_valid_next", 32'(inst_valid), 32'd1);
    check("lat_inst_pc", inst_pc, 32'h10);

    // Stall with a branch pulse mid-stall: nothing moves.
    stall = 1'b1; held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_taken = (i == 2); br_target = 32'h300;
      tick();
      if (inst_pc !== 32'h10 || !inst_valid || imem_req) held = 1'b0;
    end
    check("stall_hold", 32'(held), 32'd1);
    stall = 1'b0; br_taken = 1'b0;
    wait_req(a);
    check("stall_next", a, 32'h14);

    accept_with(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    wait_req(a);
    check("prio_trap", a, 32'h80);
    accept_with(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    wait_req(a);
    check("prio_jmp", a, 32'h200);

    accept_with(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_pc", pc, 32'h80);
    check("mis_addr", imem_addr, 32'h80);
    tick();
    check("mis_clear", 32'(misalign), 32'd0);

    accept_with(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    wait_req(a);
    check("wrap_top", a, 32'hFFFF_FFFC);
    accept_with(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    wait_req(a);
    check("wrap_zero", a, 32'h0);

    // Halt on the instruction at 0x0: pc still advances, fetching stops.
    accept_with(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req || inst_valid) held = 1'b0;
    end
    check("halt_quiet", 32'(held), 32'd1);
    check("halt_pc", pc, 32'h4);

    // Reset mid-fetch, then a stray ack during BOOT.
    ack_en = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_pc", pc, RST_PC);
    tick(); tick(); tick();
    check("rst2_fetching", 32'(imem_req), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_drops_req", 32'(imem_req), 32'd0);
    man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0;
    tick();
    man_ack = 1'b0; ack_en = 1'b1;
    check("late_ack_ignored", 32'(inst_valid), 32'd0);
    check("restart_addr", imem_addr, RST_PC);
    wait_valid();
    check("restart_inst", inst, mem_word(RST_PC));

    // Reset while an instruction is held in issue.
    stall = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0; stall = 1'b0;
    check("rst_issue_valid", 32'(inst_valid), 32'd0);
    tick(); tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
